lcd_frame_driver: RTL and testbench
===================================

// Module: lcd_frame_driver
// PURPOSE
//  Consumes the 32-char ASCII frame (256 bits) built by the CPU debug top and drives a
//  HD44780-compatible 16x2 LCD over a 4-bit write-only bus. Performs power-up init
//  once, then rewrites both lines on every refresh request. Sits directly downstream of
//  the top-level frame formatter; runs on the raw board clock CCLK.
// PARAMETERS
//  T_PWRUP  750000  cycles waited after reset before first init nibble (15 ms @50 MHz)
//  T_EXEC   2000    cycles waited after each byte/init nibble (40 us)
//  T_CLR    82000   cycles waited after Clear Display (1.64 ms)
//  T_EH     12      cycles lcd_e held high per nibble; equal low setup before and after
// PORTS
//  clk       in   1    board clock (CCLK)
//  rst       in   1    asynchronous, active-high reset
//  refresh   in   1    one-cycle-or-longer frame write request
//  strdata   in   256  frame; [255:248]=line1 col0 ... [135:128]=line1 col15, [127:120]=line2 col0
//  busy      out  1    high from reset until init done, and while a frame is being written
//  lcd_e     out  1    LCD enable strobe
//  lcd_rs    out  1    0=command, 1=data
//  lcd_rw    out  1    tied 0 (write only)
//  lcd_dat   out  4    LCD D7..D4
// BEHAVIOUR
//  - Reset (async): state=PWRUP, busy=1, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_dat=0, pending=0,
//    all counters 0. Reset mid-frame or mid-pulse aborts immediately; init reruns in full.
//  - PWRUP: wait T_PWRUP cycles. INIT: single nibbles 3,3,3,2 (each followed by T_EXEC),
//    then bytes 0x28, 0x0C, 0x06, 0x01 (0x01 followed by T_CLR). Then IDLE, busy=0.
//  - Byte write: high nibble then low nibble. Each nibble: dat/rs stable T_EH cycles,
//    e=1 for T_EH, e=0 for T_EH, dat/rs held through the whole sequence. After low nibble
//    wait T_EXEC (T_CLR for command 0x01). No busy-flag reads.
//  - Frame: [prefix] cmd 0x80, 16 data bytes line1, cmd 0xC0, 16 data bytes line2, IDLE.
//  - strdata is snapshotted into an internal 256-bit register in the cycle the request is
//    accepted; input changes during a frame do not affect it.
//  - refresh sampled every cycle: in IDLE -> accept next cycle, busy=1. Otherwise set
//    pending (one deep; extra requests coalesce). Leaving a frame with pending=1 -> clear
//    pending, snapshot, restart frame without passing through IDLE (busy stays 1).
//    Requests during PWRUP/INIT also set pending.
//  - refresh held high for many cycles = one request per accept; level re-arms pending.
//  - Char index counter 0..15 wraps to line2 address command, never beyond 31.
//  - Counters sized $clog2(max(T_*)+1); no timer overflow at any parameter value.
// CONFIGURATION
//  LCD_CLR_ON_REFRESH_EN defined: every frame prefixed with cmd 0x01 + T_CLR wait.
//  Not defined: no prefix; frame begins directly with 0x80 (no flicker, faster).
// STRUCTURE
//  Package lcd_pkg: state enum (PWRUP, INIT, IDLE, SETADDR1, LINE1, SETADDR2, LINE2),
//   command constants CMD_FUNCSET=0x28, CMD_DISPON=0x0C, CMD_ENTRY=0x06, CMD_CLR=0x01,
//   CMD_LINE1=0x80, CMD_LINE2=0xC0, init table.
//  Sub-module lcd_nibble_writer: takes {rs, nibble, last, long_wait}, produces e-pulse
//   timing and post-wait, returns done pulse. Top FSM sequences bytes/frames.
// TESTING (bench uses T_PWRUP=20, T_EXEC=4, T_CLR=10, T_EH=2)
//  1 Reset then idle -> busy=1 for init; exact nibble stream 3,3,3,2,2,8,0,C,0,6,0,1
//    with rs=0; busy falls after final T_CLR; lcd_rw=0 throughout.
//  2 refresh with strdata="HELLO..." -> cmd 0x80, bytes 'H','E',... rs=1, cmd 0xC0,
//    line2 bytes; 68 nibble pulses total (no CLR); busy=0 after last T_EXEC.
//  3 strdata altered mid-frame -> LCD receives snapshot value only.
//  4 Three refresh pulses during a frame -> exactly one extra frame, busy never drops between.
//  5 rst asserted mid-pulse with lcd_e=1 -> lcd_e=0 same cycle (async), init sequence repeats.
//  6 LCD_CLR_ON_REFRESH_EN build -> each frame starts with nibbles 0,1 and T_CLR wait.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 16x2 frame driver.
package lcd_pkg;

  // Top-level sequencer states. CLRPFX is only entered when the clear-on-refresh
  // option is compiled in.
  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    CLRPFX,
    SETADDR1,
    LINE1,
    SETADDR2,
    LINE2
  } lcd_state_t;

  // Phases of a single nibble strobe plus its optional post-write wait.
  typedef enum logic [2:0] {
    W_IDLE,
    W_SETUP,
    W_HIGH,
    W_LOW,
    W_WAIT
  } wr_state_t;

  localparam logic [7:0] CMD_FUNCSET = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_CLR     = 8'h01;
  localparam logic [7:0] CMD_LINE1   = 8'h80;
  localparam logic [7:0] CMD_LINE2   = 8'hC0;

  // Init table: the first INIT_NIBBLES entries go out as a lone low nibble
  // (8-bit -> 4-bit mode switch), the rest as full bytes.
  localparam int unsigned INIT_LEN     = 8;
  localparam int unsigned INIT_NIBBLES = 4;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0, 3'd1, 3'd2: b = 8'h03;
      3'd3:             b = 8'h02;
      3'd4:             b = CMD_FUNCSET;
      3'd5:             b = CMD_DISPON;
      3'd6:             b = CMD_ENTRY;
      default:          b = CMD_CLR;
    endcase
    return b;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one 4-bit LCD write: data/rs setup, enable pulse, hold, then an
// optional execution wait; pulses done for one cycle when finished.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_EXEC = 2000,
  parameter int unsigned T_CLR  = 82000,
  parameter int unsigned T_EH   = 12,
  parameter int unsigned CW     = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nib,
  input  logic       last,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_dat
);

  localparam logic [CW-1:0] EH_END   = CW'(T_EH - 1);
  localparam logic [CW-1:0] EXEC_END = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] CLR_END  = CW'(T_CLR - 1);

  wr_state_t     st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] wait_end;
  logic          last_q, long_q, done_nx;

  assign wait_end = long_q ? CLR_END : EXEC_END;
  assign lcd_e    = (st == W_HIGH);

  // Phase register; rs/data latched at start and held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= W_IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_dat <= '0;
      last_q  <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      st   <= st_nx;
      cnt  <= cnt_nx;
      done <= done_nx;
      if (st == W_IDLE && start) begin
        lcd_rs  <= rs;
        lcd_dat <= nib;
        last_q  <= last;
        long_q  <= long_wait;
      end
    end
  end

  // Phase sequencing: each phase runs its own count from zero.
  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt + 1'b1;
    done_nx = 1'b0;
    case (st)
      W_IDLE: begin
        cnt_nx = '0;
        if (start) st_nx = W_SETUP;
      end
      W_SETUP: if (cnt == EH_END) begin
        cnt_nx = '0;
        st_nx  = W_HIGH;
      end
      W_HIGH: if (cnt == EH_END) begin
        cnt_nx = '0;
        st_nx  = W_LOW;
      end
      W_LOW: if (cnt == EH_END) begin
        cnt_nx = '0;
        if (last_q) begin
          st_nx = W_WAIT;
        end else begin
          st_nx   = W_IDLE;
          done_nx = 1'b1;
        end
      end
      W_WAIT: if (cnt == wait_end) begin
        cnt_nx  = '0;
        st_nx   = W_IDLE;
        done_nx = 1'b1;
      end
      default: st_nx = W_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_frame_driver.sv
// HD44780 16x2 frame driver: one-time power-up init, then rewrites both lines
// from a 256-bit snapshot on each refresh request.
// Optional build macro LCD_CLR_ON_REFRESH_EN: prefix every frame with Clear Display.
module lcd_frame_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned T_EH    = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         refresh,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [3:0]   lcd_dat
);

  localparam int unsigned   CW      = $clog2(max4(T_PWRUP, T_EXEC, T_CLR, T_EH) + 1);
  localparam logic [CW-1:0] PWR_END = CW'(T_PWRUP - 1);

`ifdef LCD_CLR_ON_REFRESH_EN
  localparam lcd_state_t FRAME_FIRST = CLRPFX;
`else
  localparam lcd_state_t FRAME_FIRST = SETADDR1;
`endif

  lcd_state_t    state, state_nx;
  logic [3:0]    idx, idx_nx;
  logic          lo, lo_nx;
  logic          pend, pend_nx;
  logic          wait_q, wait_nx;
  logic [CW-1:0] tmr, tmr_nx;
  logic [255:0]  snap;
  logic          snap_ld, seq_end;

  logic [7:0]    cur_byte;
  logic          cur_rs, single;
  logic [4:0]    pos;
  logic          sending, wr_start, wr_done, byte_done;
  logic [3:0]    wr_nib;
  logic          wr_last, wr_long;

  assign lcd_rw    = 1'b0;
  assign busy      = (state != IDLE);
  assign sending   = (state != PWRUP) && (state != IDLE);
  assign wr_start  = sending && !wait_q;
  assign wr_last   = single || lo;
  assign wr_nib    = wr_last ? cur_byte[3:0] : cur_byte[7:4];
  assign wr_long   = wr_last && !cur_rs && (cur_byte == CMD_CLR);
  assign byte_done = wr_done && wr_last;

  // Byte currently being sent, chosen by state and character index.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    single   = 1'b0;
    pos      = {(state == LINE2), idx};
    case (state)
      INIT: begin
        cur_byte = init_byte(idx[2:0]);
        single   = (idx < 4'(INIT_NIBBLES));
      end
      CLRPFX:   cur_byte = CMD_CLR;
      SETADDR1: cur_byte = CMD_LINE1;
      SETADDR2: cur_byte = CMD_LINE2;
      LINE1, LINE2: begin
        // char 0 sits in the top byte, so bit offset is 8*(31-pos)
        cur_byte = snap[{~pos, 3'b000} +: 8];
        cur_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer next-state: init table, frame order, request pending/coalescing.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    lo_nx    = lo;
    tmr_nx   = tmr;
    snap_ld  = 1'b0;
    seq_end  = 1'b0;
    wait_nx  = wait_q;
    pend_nx  = pend | (refresh && (state != IDLE));

    if (wr_start)     wait_nx = 1'b1;
    else if (wr_done) wait_nx = 1'b0;

    if (byte_done)    lo_nx = 1'b0;
    else if (wr_done) lo_nx = 1'b1;

    case (state)
      PWRUP: begin
        if (tmr == PWR_END) begin
          tmr_nx   = '0;
          state_nx = INIT;
        end else begin
          tmr_nx = tmr + 1'b1;
        end
      end
      IDLE: if (refresh || pend) begin
        state_nx = FRAME_FIRST;
        snap_ld  = 1'b1;
        pend_nx  = 1'b0;
      end
      INIT: if (byte_done) begin
        if (idx == 4'(INIT_LEN - 1)) begin
          idx_nx  = '0;
          seq_end = 1'b1;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      CLRPFX:   if (byte_done) state_nx = SETADDR1;
      SETADDR1: if (byte_done) state_nx = LINE1;
      LINE1: if (byte_done) begin
        if (idx == 4'd15) begin
          idx_nx   = '0;
          state_nx = SETADDR2;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      SETADDR2: if (byte_done) state_nx = LINE2;
      LINE2: if (byte_done) begin
        if (idx == 4'd15) begin
          idx_nx  = '0;
          seq_end = 1'b1;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      default: ;
    endcase

    // A request queued during init or a frame chains straight into a new frame,
    // so busy never drops in between.
    if (seq_end) begin
      if (pend) begin
        pend_nx  = 1'b0;
        snap_ld  = 1'b1;
        state_nx = FRAME_FIRST;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  // Sequencer registers and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PWRUP;
      idx    <= '0;
      lo     <= 1'b0;
      pend   <= 1'b0;
      wait_q <= 1'b0;
      tmr    <= '0;
      snap   <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      lo     <= lo_nx;
      pend   <= pend_nx;
      wait_q <= wait_nx;
      tmr    <= tmr_nx;
      if (snap_ld) snap <= strdata;
    end
  end

  lcd_nibble_writer #(
    .T_EXEC (T_EXEC),
    .T_CLR  (T_CLR),
    .T_EH   (T_EH),
    .CW     (CW)
  ) u_writer (
    .clk       (clk),
    .rst       (rst),
    .start     (wr_start),
    .rs        (cur_rs),
    .nib       (wr_nib),
    .last      (wr_last),
    .long_wait (wr_long),
    .done      (wr_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_dat   (lcd_dat)
  );

endmodule

// File: tb/tb_lcd_frame_driver.sv
// Self-checking bench for lcd_frame_driver: captures every enable pulse and
// compares the nibble stream and its timing with a model built from the LCD
// protocol rules. Honours LCD_CLR_ON_REFRESH_EN if defined.
`timescale 1ns/1ps
module tb_lcd_frame_driver;

  localparam int unsigned T_PWRUP = 20;
  localparam int unsigned T_EXEC  = 4;
  localparam int unsigned T_CLR   = 10;
  localparam int unsigned T_EH    = 2;
  localparam int unsigned SLACK   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         refresh = 1'b0;
  logic [255:0] strdata = '0;
  logic         busy, lcd_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_dat;

  lcd_frame_driver #(
    .T_PWRUP (T_PWRUP),
    .T_EXEC  (T_EXEC),
    .T_CLR   (T_CLR),
    .T_EH    (T_EH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .refresh (refresh),
    .strdata (strdata),
    .busy    (busy),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_rw  (lcd_rw),
    .lcd_dat (lcd_dat)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor ----------------
  int unsigned cyc = 0;
  logic        prev_e = 1'b0;
  logic [4:0]  prev_bus = '0;
  logic [4:0]  bus;
  int unsigned stable = 0, hi_len = 0, low_len = 0;
  bit          after_fall = 0;
  logic [4:0]  got_q[$];
  int unsigned rise_q[$];
  int unsigned fall_q[$];
  int unsigned rw_bad = 0, timing_bad = 0;

  always @(negedge clk) begin
    cyc++;
    bus = {lcd_rs, lcd_dat};
    if (lcd_rw !== 1'b0) rw_bad++;
    if (rst) begin
      prev_e     = 1'b0;
      prev_bus   = bus;
      stable     = 0;
      hi_len     = 0;
      after_fall = 0;
    end else begin
      if (bus != prev_bus) begin
        if (lcd_e || (after_fall && low_len < T_EH)) timing_bad++;
        stable     = 1;
        after_fall = 0;
      end else begin
        stable++;
      end
      if (lcd_e && !prev_e) begin
        if (stable < T_EH + 1) timing_bad++;
        got_q.push_back(bus);
        rise_q.push_back(cyc);
        fall_q.push_back(0);
        hi_len = 1;
      end else if (lcd_e) begin
        hi_len++;
      end else if (prev_e) begin
        if (hi_len != T_EH) timing_bad++;
        fall_q[fall_q.size()-1] = cyc;
        after_fall = 1;
        low_len    = 1;
      end else if (after_fall) begin
        low_len++;
      end
      prev_e   = lcd_e;
      prev_bus = bus;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0] bus;
    logic [7:0] wt;   // wait owed after this nibble (0 between high and low nibble)
  } nib_t;

  nib_t exp_q[$];

  function automatic void push_nib(input logic rs, input logic [3:0] n, input int unsigned wt);
    nib_t e;
    e.bus = {rs, n};
    e.wt  = 8'(wt);
    exp_q.push_back(e);
  endfunction

  function automatic void push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4], 0);
    push_nib(rs, b[3:0], (!rs && b == 8'h01) ? T_CLR : T_EXEC);
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 3; i++) push_nib(1'b0, 4'h3, T_EXEC);
    push_nib(1'b0, 4'h2, T_EXEC);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endfunction

  function automatic void model_frame(input logic [255:0] s);
`ifdef LCD_CLR_ON_REFRESH_EN
    push_byte(1'b0, 8'h01);
`endif
    push_byte(1'b0, 8'h80);
    for (int c = 0; c < 32; c++) begin
      if (c == 16) push_byte(1'b0, 8'hC0);
      push_byte(1'b1, s[255 - 8*c -: 8]);
    end
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok, output int unsigned t);
    ok = 0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) begin
        ok = 1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_nibs(input int unsigned n, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if (got_q.size() >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic compare_run(input string name, input int unsigned g0, input bit ok,
                             input int unsigned t_end);
    int unsigned gap, mn, last;
    check({name, "_count"}, 64'(got_q.size() - g0), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (g0 + i >= got_q.size()) break;
      check($sformatf("%s_nib%0d", name, i), got_q[g0+i], exp_q[i].bus);
      if (i > 0) begin
        gap = rise_q[g0+i] - fall_q[g0+i-1];
        mn  = 2*T_EH + exp_q[i-1].wt;
        check($sformatf("%s_gap%0d(gap %0d min %0d)", name, i, gap, mn),
              64'(gap >= mn && gap <= mn + SLACK), 64'd1);
      end
    end
    if (ok && got_q.size() > g0) begin
      last = got_q.size() - 1;
      gap  = t_end - fall_q[last];
      mn   = T_EH + exp_q[exp_q.size()-1].wt;
      check($sformatf("%s_busy_fall(lat %0d min %0d)", name, gap, mn),
            64'(gap >= mn && gap <= mn + SLACK), 64'd1);
    end
  endtask

  task automatic check_pwrup(input string name, input int unsigned g0, input int unsigned rel);
    int unsigned d, mn;
    mn = T_PWRUP + T_EH;
    if (got_q.size() > g0) begin
      d = rise_q[g0] - rel;
      check($sformatf("%s_pwrup(dly %0d min %0d)", name, d, mn),
            64'(d >= mn && d <= mn + SLACK), 64'd1);
    end else begin
      check({name, "_pwrup_nibble"}, 64'(got_q.size()), 64'(g0 + 1));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] a, b;
    logic [127:0] l1;
    int unsigned  g0, t_end, rel;
    bit           ok;

    // 1: reset state and power-up init
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 1);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_dat", lcd_dat, 0);
    check("rst_rw", lcd_rw, 0);
    g0  = got_q.size();
    rel = cyc;
    rst = 1'b0;
    exp_q.delete();
    model_init();
    repeat (T_PWRUP / 2) tick();
    check("pwrup_busy", busy, 1);
    wait_idle(5000, ok, t_end);
    check("init_done", ok, 1);
    compare_run("init", g0, ok, t_end);
    check_pwrup("init", g0, rel);
    repeat (5) tick();
    check("idle_busy", busy, 0);

    // 2: frame from idle, known text on line 1
    l1 = "HELLO, LCD 16x2!";
    a  = rand_frame();
    a[255:128] = l1;
    strdata = a;
    g0 = got_q.size();
    exp_q.delete();
    model_frame(a);
    pulse_refresh();
    check("accept_busy", busy, 1);
    wait_idle(5000, ok, t_end);
    check("frame_done", ok, 1);
    compare_run("hello", g0, ok, t_end);

    // 3: input changes mid-frame are ignored
    repeat ($urandom_range(1, 6)) tick();
    a = rand_frame();
    strdata = a;
    g0 = got_q.size();
    exp_q.delete();
    model_frame(a);
    pulse_refresh();
    wait_nibs(g0 + 20, ok);
    check("snap_mid", ok, 1);
    strdata = rand_frame();
    wait_idle(5000, ok, t_end);
    check("snap_done", ok, 1);
    compare_run("snap", g0, ok, t_end);

    // 4: three requests during a frame coalesce into one extra frame
    repeat ($urandom_range(1, 6)) tick();
    a = rand_frame();
    strdata = a;
    g0 = got_q.size();
    exp_q.delete();
    model_frame(a);
    pulse_refresh();
    wait_nibs(g0 + 10, ok);
    check("coal_mid", ok, 1);
    b = rand_frame();
    strdata = b;
    model_frame(b);
    for (int i = 0; i < 3; i++) begin
      pulse_refresh();
      repeat ($urandom_range(2, 9)) tick();
    end
    wait_idle(10000, ok, t_end);
    check("coal_done", ok, 1);
    compare_run("coal", g0, ok, t_end);
    repeat (5) tick();
    check("coal_idle", busy, 0);

    // 5: async reset while enable is high, then init reruns; a request
    //    during power-up chains straight into a frame
    a = rand_frame();
    strdata = a;
    g0 = got_q.size();
    pulse_refresh();
    wait_nibs(g0 + 30, ok);
    check("abort_mid", ok, 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (lcd_e) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("abort_e_seen", ok, 1);
    rst = 1'b1;
    #1;
    check("abort_e", lcd_e, 0);
    check("abort_busy", busy, 1);
    check("abort_dat", lcd_dat, 0);
    check("abort_rs", lcd_rs, 0);
    repeat (2) tick();
    g0  = got_q.size();
    rel = cyc;
    rst = 1'b0;
    exp_q.delete();
    model_init();
    b = rand_frame();
    strdata = b;
    model_frame(b);
    repeat (3) tick();
    pulse_refresh();
    wait_idle(10000, ok, t_end);
    check("reinit_done", ok, 1);
    compare_run("reinit", g0, ok, t_end);
    check_pwrup("reinit", g0, rel);

    check("rw_low", 64'(rw_bad), 64'd0);
    check("strobe_timing", 64'(timing_bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
